// File: rtl/mem_access_unit_if.sv
// Word-wide memory bus between the MEM-stage access unit (master) and memory (slave).
// Request/acknowledge handshake with byte-lane enables.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: lane steering, load extension and pipeline stall
// around a req/ack word bus, with misalignment detection and an ack timeout.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MemRd,
  input  logic               MemWr,
  input  logic [5:0]         Opcode,
  input  logic [31:0]        Addr,
  input  logic [31:0]        WriteData,
  output logic               Stall,
  output logic [31:0]        ReadData,
  output logic               AddrErr,
  output logic               BusErr,
  mem_access_unit_if.master  mem
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  function automatic size_t size_of(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: size_of = SZ_BYTE;
      6'h21, 6'h25, 6'h29: size_of = SZ_HALF;
      default:             size_of = SZ_WORD;
    endcase
  endfunction

  state_t      state, state_nxt;
  size_t       size;
  logic        access, misaligned, start;
  logic        acked, timed_out;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  wait_cnt;
  logic [5:0]  op_q;
  logic [1:0]  lane_q;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;

  // Request decode and store-lane steering from the EX/MEM register contents.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    size       = size_of(Opcode);
    access     = MemRd | MemWr;
    misaligned = ((size == SZ_WORD) && (Addr[1:0] != 2'b00)) ||
                 ((size == SZ_HALF) && Addr[0]);
    start      = (state == IDLE) && access && !misaligned;
    be_nxt     = 4'b1111;
    wdata_nxt  = WriteData;
    case (size)
      SZ_BYTE: begin
        be_nxt    = 4'b0001 << Addr[1:0];
        wdata_nxt = {4{WriteData[7:0]}};
      end
      SZ_HALF: begin
        be_nxt    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    acked     = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          Stall     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (mem.bus_ack) begin
          acked     = 1'b1;
          state_nxt = DONE;
        end else if (wait_cnt == CNT_LAST) begin
          timed_out = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load extraction uses the lane and opcode captured at request time.
  always_comb begin
    lane_byte = mem.bus_rdata[{lane_q, 3'b000} +: 8];
    lane_half = lane_q[1] ? mem.bus_rdata[31:16] : mem.bus_rdata[15:0];
    load_val  = mem.bus_rdata;
    case (op_q)
      6'h20:        load_val = {{24{lane_byte[7]}}, lane_byte};
      6'h24, 6'h28: load_val = {24'h000000, lane_byte};
      6'h21:        load_val = {{16{lane_half[15]}}, lane_half};
      6'h25, 6'h29: load_val = {16'h0000, lane_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      mem.bus_req   <= 1'b0;
      mem.bus_we    <= 1'b0;
      mem.bus_addr  <= '0;
      mem.bus_be    <= '0;
      mem.bus_wdata <= '0;
      ReadData      <= '0;
      AddrErr       <= 1'b0;
      BusErr        <= 1'b0;
      wait_cnt      <= '0;
      op_q          <= '0;
      lane_q        <= '0;
    end else begin
      AddrErr <= (state == IDLE) && access && misaligned;
      BusErr  <= timed_out;
      if (start) begin
        mem.bus_req   <= 1'b1;
        mem.bus_we    <= MemWr;
        mem.bus_addr  <= {Addr[31:2], 2'b00};
        mem.bus_be    <= be_nxt;
        mem.bus_wdata <= wdata_nxt;
        op_q          <= Opcode;
        lane_q        <= Addr[1:0];
        wait_cnt      <= '0;
      end
      if (acked || timed_out) mem.bus_req <= 1'b0;
      if (acked && !mem.bus_we) ReadData <= load_val;
      if (timed_out && !mem.bus_we) ReadData <= '0;
      if ((state == BUSY) && !acked && !timed_out) wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level timeline model drives
// per-cycle expectations checked on the falling edge, plus literal spot checks.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRd, MemWr;
  logic [5:0]  Opcode;
  logic [31:0] Addr, WriteData;
  logic        Stall;
  logic [31:0] ReadData;
  logic        AddrErr, BusErr;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRd     (MemRd),
    .MemWr     (MemWr),
    .Opcode    (Opcode),
    .Addr      (Addr),
    .WriteData (WriteData),
    .Stall     (Stall),
    .ReadData  (ReadData),
    .AddrErr   (AddrErr),
    .BusErr    (BusErr),
    .mem       (bus_if)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  bit          chk_en  = 1'b0;
  bit          chk_bus = 1'b0;
  bit          err_next = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_aerr, exp_berr;
  logic [31:0] exp_addr, exp_wdata, exp_rd;
  logic [3:0]  exp_be;

  int          stall_cnt, req_cnt, aerr_cnt, berr_cnt;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference rules: access size, alignment, lane enables, store replication, load extension.
  function automatic int size_bytes(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      default:             return 4;
    endcase
  endfunction

  function automatic bit model_misaligned(input logic [5:0] op, input logic [31:0] a);
    return (int'(a[1:0]) % size_bytes(op)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [5:0] op, input logic [31:0] a);
    int m;
    m = ((1 << size_bytes(op)) - 1) << int'(a[1:0]);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] wd);
    case (size_bytes(op))
      1:       return {24'h0, wd[7:0]} * 32'h01010101;
      2:       return {16'h0, wd[15:0]} * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a,
                                              input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * int'(a[1:0]));
    case (size_bytes(op))
      1: begin
        v = v & 32'h000000FF;
        if (op == 6'h20 && v[7]) v = v | 32'hFFFFFF00;
      end
      2: begin
        v = v & 32'h0000FFFF;
        if (op == 6'h21 && v[15]) v = v | 32'hFFFF0000;
      end
      default: ;
    endcase
    return v;
  endfunction

  // Per-cycle compare against the timeline expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check("Stall",    32'(Stall),          32'(exp_stall));
      check("bus_req",  32'(bus_if.bus_req), 32'(exp_req));
      check("AddrErr",  32'(AddrErr),        32'(exp_aerr));
      check("BusErr",   32'(BusErr),         32'(exp_berr));
      check("ReadData", ReadData,            exp_rd);
      if (chk_bus) begin
        check("bus_we",    32'(bus_if.bus_we), 32'(exp_we));
        check("bus_addr",  bus_if.bus_addr,    exp_addr);
        check("bus_be",    32'(bus_if.bus_be), 32'(exp_be));
        check("bus_wdata", bus_if.bus_wdata,   exp_wdata);
      end
      if (Stall === 1'b1)   stall_cnt++;
      if (AddrErr === 1'b1) aerr_cnt++;
      if (BusErr === 1'b1)  berr_cnt++;
      if (bus_if.bus_req === 1'b1) begin
        req_cnt++;
        seen_addr  = bus_if.bus_addr;
        seen_be    = bus_if.bus_be;
        seen_wdata = bus_if.bus_wdata;
        seen_we    = bus_if.bus_we;
      end
    end
  end

  task automatic clear_counts();
    stall_cnt = 0; req_cnt = 0; aerr_cnt = 0; berr_cnt = 0;
    seen_addr = '0; seen_be = '0; seen_wdata = '0; seen_we = 1'b0;
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    exp_aerr = err_next;
    err_next = 1'b0;
    exp_berr = 1'b0;
  endtask

  task automatic set_inputs(input logic rd, input logic wr, input logic [5:0] op,
                            input logic [31:0] a, input logic [31:0] wd);
    MemRd = rd; MemWr = wr; Opcode = op; Addr = a; WriteData = wd;
  endtask

  task automatic idle(input logic ack, input logic [31:0] rdata);
    begin_cycle();
    set_inputs(1'b0, 1'b0, 6'h00, 32'h0, 32'h0);
    bus_if.bus_ack   = ack;
    bus_if.bus_rdata = rdata;
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    chk_bus   = 1'b0;
  endtask

  // One EX/MEM access. waits = BUSY cycles before the ack; ack_on = 0 lets it time out.
  task automatic mem_op(input logic rd, input logic wr, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdata, input int waits, input bit ack_on);
    int  nbusy;
    bit  mis;
    mis = model_misaligned(op, a);
    begin_cycle();
    set_inputs(rd, wr, op, a, wd);
    bus_if.bus_ack = 1'b0;
    exp_req   = 1'b0;
    chk_bus   = 1'b0;
    exp_stall = !mis;
    if (mis) begin
      err_next = 1'b1;
      return;
    end
    nbusy = ack_on ? waits + 1 : TO;
    for (int i = 0; i < nbusy; i++) begin
      begin_cycle();
      exp_stall = 1'b1;
      exp_req   = 1'b1;
      chk_bus   = 1'b1;
      exp_we    = wr;
      exp_addr  = {a[31:2], 2'b00};
      exp_be    = model_be(op, a);
      exp_wdata = model_wdata(op, wd);
      bus_if.bus_ack   = ack_on && (i == nbusy - 1);
      bus_if.bus_rdata = bus_if.bus_ack ? rdata : 32'h5A5A5A5A;
    end
    begin_cycle();
    bus_if.bus_ack = 1'b0;
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    chk_bus   = 1'b0;
    exp_berr  = !ack_on;
    if (!wr) exp_rd = ack_on ? model_load(op, a, rdata) : 32'h0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    set_inputs(1'b0, 1'b0, 6'h00, 32'h0, 32'h0);
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    exp_stall = 1'b0; exp_req = 1'b0; exp_aerr = 1'b0; exp_berr = 1'b0; exp_rd = 32'h0;
    exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
    chk_bus = 1'b1;
    chk_en  = 1'b1;
    @(negedge clk);
    #1;
    check("rst_ReadData", ReadData, 32'h0);
    check("rst_bus_req", 32'(bus_if.bus_req), 32'h0);
    begin_cycle();
    reset = 1'b1;
    idle(1'b0, 32'h0);

    // Word load, ack in first BUSY cycle.
    clear_counts();
    mem_op(1'b1, 1'b0, 6'h23, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1'b1);
    check("lw_stall_cycles", 32'(stall_cnt), 32'd2);
    check("lw_ReadData", ReadData, 32'hDEADBEEF);
    check("lw_bus_addr", seen_addr, 32'h10);
    check("lw_bus_be", 32'(seen_be), 32'hF);

    // Signed and unsigned byte loads from lane 3.
    mem_op(1'b1, 1'b0, 6'h20, 32'h13, 32'h0, 32'h80FF00AA, 0, 1'b1);
    check("lb_ReadData", ReadData, 32'hFFFFFF80);
    check("lb_bus_be", 32'(seen_be), 32'h8);
    mem_op(1'b1, 1'b0, 6'h24, 32'h13, 32'h0, 32'h80FF00AA, 0, 1'b1);
    check("lbu_ReadData", ReadData, 32'h00000080);

    // Halfword store to upper lanes leaves ReadData alone.
    mem_op(1'b0, 1'b1, 6'h29, 32'h22, 32'h0000BEEF, 32'h0, 0, 1'b1);
    check("sh_bus_we", 32'(seen_we), 32'h1);
    check("sh_bus_be", 32'(seen_be), 32'hC);
    check("sh_bus_wdata", seen_wdata, 32'hBEEFBEEF);
    check("sh_ReadData", ReadData, 32'h00000080);

    // Halfword loads with wait states, byte store, read+write collision, unknown opcode.
    clear_counts();
    mem_op(1'b1, 1'b0, 6'h21, 32'h02, 32'h0, 32'h80017FFF, 2, 1'b1);
    check("lh_stall_cycles", 32'(stall_cnt), 32'd4);
    check("lh_ReadData", ReadData, 32'hFFFF8001);
    mem_op(1'b1, 1'b0, 6'h25, 32'h00, 32'h0, 32'h8001F00D, 1, 1'b1);
    check("lhu_ReadData", ReadData, 32'h0000F00D);
    mem_op(1'b0, 1'b1, 6'h28, 32'h41, 32'h123456A5, 32'h0, 0, 1'b1);
    check("sb_bus_wdata", seen_wdata, 32'hA5A5A5A5);
    check("sb_bus_be", 32'(seen_be), 32'h2);
    mem_op(1'b1, 1'b1, 6'h2B, 32'h80, 32'hCAFEF00D, 32'h11111111, 0, 1'b1);
    check("rdwr_bus_we", 32'(seen_we), 32'h1);
    check("rdwr_ReadData", ReadData, 32'h0000F00D);
    mem_op(1'b1, 1'b0, 6'h3F, 32'h0C, 32'h0, 32'h13579BDF, 0, 1'b1);
    check("other_op_ReadData", ReadData, 32'h13579BDF);

    // Misaligned word load then misaligned halfword store.
    idle(1'b0, 32'h0);
    clear_counts();
    mem_op(1'b1, 1'b0, 6'h23, 32'h06, 32'h0, 32'h0, 0, 1'b1);
    mem_op(1'b0, 1'b1, 6'h29, 32'h05, 32'hFFFF, 32'h0, 0, 1'b1);
    idle(1'b0, 32'h0);
    idle(1'b0, 32'h0);
    @(negedge clk);
    #1;
    check("mis_addrerr_pulses", 32'(aerr_cnt), 32'd2);
    check("mis_req_cycles", 32'(req_cnt), 32'd0);
    check("mis_stall_cycles", 32'(stall_cnt), 32'd0);

    // Reset asserted during the third BUSY cycle of a load.
    begin_cycle();
    set_inputs(1'b1, 1'b0, 6'h23, 32'h40, 32'h0);
    exp_stall = 1'b1;
    exp_req   = 1'b0;
    chk_bus   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      begin_cycle();
      exp_stall = 1'b1; exp_req = 1'b1; chk_bus = 1'b1;
      exp_we = 1'b0; exp_addr = 32'h40; exp_be = 4'hF; exp_wdata = 32'h0;
      if (i == 2) reset = 1'b0;
    end
    begin_cycle();
    reset = 1'b1;
    set_inputs(1'b0, 1'b0, 6'h00, 32'h0, 32'h0);
    exp_stall = 1'b0; exp_req = 1'b0; exp_rd = 32'h0;
    chk_bus = 1'b1; exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
    @(negedge clk);
    #1;
    check("midrst_bus_req", 32'(bus_if.bus_req), 32'h0);
    check("midrst_Stall", 32'(Stall), 32'h0);
    check("midrst_ReadData", ReadData, 32'h0);

    clear_counts();
    mem_op(1'b1, 1'b0, 6'h23, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1'b1);
    check("postrst_stall_cycles", 32'(stall_cnt), 32'd2);
    check("postrst_ReadData", ReadData, 32'hDEADBEEF);

    // Timeout with no ack, then a stray ack while idle.
    clear_counts();
    mem_op(1'b1, 1'b0, 6'h23, 32'h20, 32'h0, 32'h0, 0, 1'b0);
    check("to_req_cycles", 32'(req_cnt), 32'd4);
    check("to_buserr_pulses", 32'(berr_cnt), 32'd1);
    check("to_ReadData", ReadData, 32'h0);
    idle(1'b1, 32'hFFFFFFFF);
    idle(1'b1, 32'hFFFFFFFF);
    idle(1'b0, 32'h0);
    @(negedge clk);
    #1;
    check("late_ack_ReadData", ReadData, 32'h0);
    check("late_ack_bus_req", 32'(bus_if.bus_req), 32'h0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage memory access unit of the pipelined CPU. Consumes the control, address and store data held in the EX/MEM pipeline register and performs the load or store on a word-wide memory bus with a req/ack handshake. Handles byte and halfword lanes and load extension, and stalls the pipeline until the bus completes. Supplies load data to the MEM/WB register.

## Interface
Parameters:
- TIMEOUT, 255: maximum BUSY cycles without bus_ack before the access is aborted (1..255).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- MemRd  in  1  load request from EX/MEM
- MemWr  in  1  store request from EX/MEM; wins if MemRd is also high
- Opcode  in  6  instruction opcode from EX/MEM; selects size and extension
- Addr  in  32  byte address (EX/MEM ALUOut)
- WriteData  in  32  store data, right-aligned
- Stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM while high
- ReadData  out  32  extended load result
- AddrErr  out  1  one-cycle pulse: misaligned access, no bus transaction
- BusErr  out  1  one-cycle pulse in DONE: access aborted by timeout
- bus_req  out  1  access request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {Addr[31:2],2'b00}
- bus_be  out  4  byte enables, bit i = byte lane i (little-endian)
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  completion strobe

## Operation
- Sizes: lw 0x23 and sw 0x2B are word. lh 0x21, lhu 0x25 and sh 0x29 are half. lb 0x20, lbu 0x24 and sb 0x28 are byte. Any other opcode with MemRd or MemWr is treated as word.
- Misaligned: a word access with Addr[1:0]≠0, or a half access with Addr[0]≠0.
- Byte access:
  - bus_be = 4'b0001 << Addr[1:0]
  - bus_wdata = {4{WriteData[7:0]}}
- Half access:
  - bus_be = Addr[1] ? 4'b1100 : 4'b0011
  - bus_wdata = {2{WriteData[15:0]}}
- Word access: bus_be = 4'b1111 and bus_wdata = WriteData.
- Load extension: select the byte or half lane using the latched Addr[1:0]. lb and lh sign-extend; lbu and lhu zero-extend.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, with MemRd|MemWr and aligned:
    - Stall = 1 (combinational).
    - Register bus_addr, bus_we, bus_be, bus_wdata, the opcode and Addr[1:0].
    - Set bus_req = 1, clear the timeout counter, go to BUSY.
  - IDLE, misaligned: AddrErr = 1 (registered, next cycle). No stall, no bus_req. Stay in IDLE.
  - BUSY: Stall = 1 and bus_req = 1.
    - On bus_ack: load ReadData if the access is a read, drop bus_req, go to DONE.
    - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without ack: drop bus_req, set BusErr, set ReadData = 0 if read, go to DONE.
  - DONE: Stall = 0, so EX/MEM advances at the end of this cycle. BusErr is high only in DONE after a timeout. Go to IDLE unconditionally; no new request is accepted in DONE.
- ReadData is registered. It holds its last value until the next completed load and is not changed by stores.
- bus_ack seen in IDLE or DONE is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - Stall is low in IDLE with no request.
  - ReadData = 0; AddrErr, BusErr, bus_req and bus_we = 0; bus_addr = 0; bus_be = 0; bus_wdata = 0.
- Reset low during BUSY: bus_req = 0 at that edge with no capture; return to IDLE.
- Latency with ack in the first BUSY cycle:
  - cycle 0 IDLE, stall
  - cycle 1 BUSY, ack
  - cycle 2 DONE, ReadData valid
  - 2 stall cycles in total.
- Each extra wait cycle adds one stall cycle.
- bus_req rises on the edge leaving IDLE and falls on the edge after bus_ack is sampled. bus_addr, bus_we, bus_be and bus_wdata are stable for the whole of bus_req.
- Back-to-back accesses: a minimum of one DONE cycle separates two bus_req pulses.

## Test plan
- lw at Addr 0x00000010, bus_rdata 0xDEADBEEF, ack in the first BUSY cycle:
  - bus_addr 0x10, bus_be 4'b1111, Stall high 2 cycles
  - ReadData 0xDEADBEEF in DONE
- lb at 0x13, then lbu at 0x13, both with rdata 0x80FF00AA: ReadData 0xFFFFFF80, then 0x00000080.
- sh at 0x22 with WriteData 0x0000BEEF:
  - bus_we 1, bus_be 4'b1100, bus_wdata 0xBEEFBEEF
  - ReadData unchanged
- lw at 0x06, then sh at 0x05:
  - AddrErr pulses each time
  - bus_req never asserted, Stall stays 0
- TIMEOUT = 4, lw with no ack:
  - bus_req high 4 cycles, then DONE with BusErr = 1 and ReadData 0
  - ReadData 0; a later ack is ignored
- reset low during the 3rd BUSY cycle:
  - next cycle IDLE, bus_req 0, Stall 0, ReadData 0
  - after reset a lw with ack behaves as in the first scenario
